// File: rtl/espirometro_fsm_param.sv
// Spirometer game controller: start on valid weight, wait for airflow, timed window, win/lose.
// Defining ESPIRO_TIMEOUT_EN adds a timeout to the wait state that consumes an attempt.
module espirometro_fsm_param #(
   parameter int                PESO_W         = 8,
   parameter int                LED_W          = 3,
   parameter logic [PESO_W-1:0] PESO_MIN       = 8'd20,
   parameter int                LED_INICIO     = 3,
   parameter int                LED_META       = 7,
   parameter int                VENTANA_CICLOS = 1000,
   parameter int                MAX_INTENTOS   = 3,
   parameter int                ESPERA_CICLOS  = 5000
) (
   input  logic                              iClk,
   input  logic                              iReset,
   input  logic                              iCE,
   input  logic [PESO_W-1:0]                 ivPeso,
   input  logic                              iBoton,
   input  logic [LED_W-1:0]                  ivLED,
   output logic [2:0]                        ovState_Machine,
   output logic [$clog2(MAX_INTENTOS+1)-1:0] ovIntentos,
   output logic [LED_W-1:0]                  ovPico,
   output logic                              oFin
);

   localparam int INT_W   = $clog2(MAX_INTENTOS + 1);
   // One counter serves both windows, so it is sized for the longer one.
   localparam int TMR_LIM = (VENTANA_CICLOS > ESPERA_CICLOS) ? VENTANA_CICLOS : ESPERA_CICLOS;
   localparam int TMR_W   = (TMR_LIM > 2) ? $clog2(TMR_LIM) : 1;

   localparam logic [TMR_W-1:0] VENT_FIN   = TMR_W'(VENTANA_CICLOS - 1);
   localparam logic [LED_W-1:0] LED_INI_V  = LED_W'(LED_INICIO);
   localparam logic [LED_W-1:0] LED_META_V = LED_W'(LED_META);
   localparam logic [INT_W-1:0] MAX_INT_V  = INT_W'(MAX_INTENTOS);
`ifdef ESPIRO_TIMEOUT_EN
   localparam logic [TMR_W-1:0] ESP_FIN    = TMR_W'(ESPERA_CICLOS - 1);
`endif

   typedef enum logic [2:0] {
      INICIO   = 3'd0,
      ESPERA   = 3'd1,
      MEDICION = 3'd2,
      GANA     = 3'd3,
      PIERDE   = 3'd4
   } estado_t;

   estado_t          state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [INT_W-1:0] int_q, int_d, int_inc;
   logic [LED_W-1:0] pico_q, pico_d;
   logic             prev_q;
   logic             fin_q, fin_d;
   logic             evento;

   assign evento  = iBoton & ~prev_q;
   assign int_inc = (int_q < MAX_INT_V) ? int_q + INT_W'(1) : int_q;

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         state_q <= INICIO;
         tmr_q   <= '0;
         int_q   <= '0;
         pico_q  <= '0;
         prev_q  <= 1'b0;
         fin_q   <= 1'b0;
      end else if (iCE) begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         int_q   <= int_d;
         pico_q  <= pico_d;
         prev_q  <= iBoton;
         fin_q   <= fin_d;
      end else begin
         fin_q   <= 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      int_d   = int_q;
      pico_d  = pico_q;
      fin_d   = 1'b0;
      case (state_q)
         INICIO: begin
            if (evento && (ivPeso >= PESO_MIN)) begin
               state_d = ESPERA;
               tmr_d   = '0;
               int_d   = '0;
               pico_d  = '0;
            end
         end
         ESPERA: begin
            if (ivLED >= LED_INI_V) begin
               state_d = MEDICION;
               tmr_d   = '0;
            end
`ifdef ESPIRO_TIMEOUT_EN
            else if (tmr_q == ESP_FIN) begin
               int_d   = int_inc;
               tmr_d   = '0;
               state_d = (int_inc == MAX_INT_V) ? PIERDE : ESPERA;
            end else begin
               tmr_d   = tmr_q + TMR_W'(1);
            end
`endif
         end
         MEDICION: begin
            pico_d = (ivLED > pico_q) ? ivLED : pico_q;
            // A win on the last window cycle beats the expiry.
            if (ivLED >= LED_META_V) begin
               state_d = GANA;
               tmr_d   = '0;
            end else if (tmr_q == VENT_FIN) begin
               int_d   = int_inc;
               tmr_d   = '0;
               state_d = (int_inc == MAX_INT_V) ? PIERDE : ESPERA;
            end else begin
               tmr_d   = tmr_q + TMR_W'(1);
            end
         end
         GANA, PIERDE: begin
            if (evento) state_d = INICIO;
         end
         default: state_d = INICIO;
      endcase
      fin_d = ((state_d == GANA) || (state_d == PIERDE)) && (state_d != state_q);
   end

   assign ovState_Machine = state_q;
   assign ovIntentos      = int_q;
   assign ovPico          = pico_q;
   assign oFin            = fin_q;

endmodule
